// File: rtl/dmem_ctrl.sv
// Load/store controller between an RV32I-style request port and a word-wide data memory.
// Sub-word stores are a read-modify-write: ACCESS reads the word, MERGE writes it back.
module dmem_ctrl #(
    parameter int unsigned MEM_BYTES = 128
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic        i_req_we,
    input  logic [2:0]  i_req_funct3,
    input  logic [31:0] i_req_addr,
    input  logic [31:0] i_req_wdata,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_rdata,
    output logic        o_rsp_err,
    output logic        o_mem_we,
    output logic [31:0] o_mem_addr,
    output logic [31:0] o_mem_wd,
    input  logic [31:0] i_mem_rd
);

    localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

    typedef enum logic [1:0] {
        StIdle,
        StAccess,
        StMerge,
        StResp
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [31:0] r_addr;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_word;

    logic        w_accept;
    logic        w_f3_ok;
    logic        w_misalign;
    logic        w_oob;
    logic        w_req_err;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load_val;
    logic [31:0] w_merge;
    logic        w_is_sw;

    assign o_req_ready = (r_state == StIdle);
    assign o_rsp_valid = (r_state == StResp);
    assign o_rsp_rdata = r_rdata;
    assign o_rsp_err   = r_err;
    assign w_accept    = i_req_valid && (r_state == StIdle);
    assign w_is_sw     = r_we && (r_funct3 == 3'b010);

    // Request legality, evaluated on the raw request so the error path skips memory entirely.
    always_comb begin
        if (i_req_we) begin
            w_f3_ok = (i_req_funct3 == 3'b000) || (i_req_funct3 == 3'b001) ||
                      (i_req_funct3 == 3'b010);
        end else begin
            w_f3_ok = (i_req_funct3 == 3'b000) || (i_req_funct3 == 3'b001) ||
                      (i_req_funct3 == 3'b010) || (i_req_funct3 == 3'b100) ||
                      (i_req_funct3 == 3'b101);
        end
        w_misalign = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                     ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
        w_oob      = (i_req_addr >= MEM_LIMIT);
        w_req_err  = !w_f3_ok || w_misalign || w_oob;
    end

    always_comb begin
        w_byte = 8'h00;
        unique case (r_addr[1:0])
            2'b00: w_byte = i_mem_rd[7:0];
            2'b01: w_byte = i_mem_rd[15:8];
            2'b10: w_byte = i_mem_rd[23:16];
            2'b11: w_byte = i_mem_rd[31:24];
            default: w_byte = 8'h00;
        endcase
        w_half = r_addr[1] ? i_mem_rd[31:16] : i_mem_rd[15:0];

        w_load_val = 32'h0;
        case (r_funct3)
            3'b000:  w_load_val = {{24{w_byte[7]}}, w_byte};
            3'b001:  w_load_val = {{16{w_half[15]}}, w_half};
            3'b010:  w_load_val = i_mem_rd;
            3'b100:  w_load_val = {24'h0, w_byte};
            3'b101:  w_load_val = {16'h0, w_half};
            default: w_load_val = 32'h0;
        endcase
    end

    // Replace only the addressed lane of the word captured in ACCESS.
    always_comb begin
        w_merge = r_word;
        if (r_funct3[1:0] == 2'b00) begin
            case (r_addr[1:0])
                2'b00:   w_merge[7:0]   = r_wdata[7:0];
                2'b01:   w_merge[15:8]  = r_wdata[7:0];
                2'b10:   w_merge[23:16] = r_wdata[7:0];
                default: w_merge[31:24] = r_wdata[7:0];
            endcase
        end else if (r_addr[1]) begin
            w_merge[31:16] = r_wdata[15:0];
        end else begin
            w_merge[15:0] = r_wdata[15:0];
        end
    end

    // Memory port is decoded from state only, so reset silences it immediately.
    always_comb begin
        o_mem_we   = 1'b0;
        o_mem_addr = 32'h0;
        o_mem_wd   = 32'h0;
        case (r_state)
            StAccess: begin
                o_mem_addr = {r_addr[31:2], 2'b00};
                if (w_is_sw) begin
                    o_mem_we = 1'b1;
                    o_mem_wd = r_wdata;
                end
            end
            StMerge: begin
                o_mem_addr = {r_addr[31:2], 2'b00};
                o_mem_we   = 1'b1;
                o_mem_wd   = w_merge;
            end
            default: begin
                o_mem_we   = 1'b0;
                o_mem_addr = 32'h0;
                o_mem_wd   = 32'h0;
            end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    w_state_nxt = w_req_err ? StResp : StAccess;
                end
            end
            StAccess: begin
                w_state_nxt = (r_we && !w_is_sw) ? StMerge : StResp;
            end
            StMerge: begin
                w_state_nxt = StResp;
            end
            StResp: begin
                if (i_rsp_ready) begin
                    w_state_nxt = StIdle;
                end
            end
            default: w_state_nxt = StIdle;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state  <= StIdle;
            r_addr   <= 32'h0;
            r_we     <= 1'b0;
            r_funct3 <= 3'b000;
            r_wdata  <= 32'h0;
            r_rdata  <= 32'h0;
            r_err    <= 1'b0;
            r_word   <= 32'h0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_addr   <= i_req_addr;
                r_we     <= i_req_we;
                r_funct3 <= i_req_funct3;
                r_wdata  <= i_req_wdata;
                r_err    <= w_req_err;
                r_rdata  <= 32'h0;
            end
            if (r_state == StAccess) begin
                if (!r_we) begin
                    r_rdata <= w_load_val;
                end else begin
                    r_word <= i_mem_rd;
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: a word-array reference model predicts responses and writes,
// a negedge monitor compares whatever the DUT presents.
module tb_dmem_ctrl;

    localparam int unsigned MEM_BYTES = 128;
    localparam int          AW        = $clog2(MEM_BYTES);
    localparam int          NWORDS    = MEM_BYTES / 4;

    typedef struct {
        logic [31:0] rd;
        bit          err;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
    } wr_t;

    logic        i_clk;
    logic        i_reset;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [2:0]  i_req_funct3;
    logic [31:0] i_req_addr;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic        o_mem_we;
    logic [31:0] o_mem_addr;
    logic [31:0] o_mem_wd;
    logic [31:0] i_mem_rd;

    logic [31:0] mem     [NWORDS];
    logic [31:0] ref_mem [NWORDS];
    exp_t        rq[$];
    wr_t         wq[$];
    int          n_cmp;
    int          n_bad;
    int          cyc;
    bit          bp_on;

    dmem_ctrl #(.MEM_BYTES(MEM_BYTES)) dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_req_we     (i_req_we),
        .i_req_funct3 (i_req_funct3),
        .i_req_addr   (i_req_addr),
        .i_req_wdata  (i_req_wdata),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_rdata  (o_rsp_rdata),
        .o_rsp_err    (o_rsp_err),
        .o_mem_we     (o_mem_we),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wd     (o_mem_wd),
        .i_mem_rd     (i_mem_rd)
    );

    assign i_mem_rd = mem[o_mem_addr[AW-1:2]];

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        cyc = 0;
        forever begin
            @(posedge i_clk);
            cyc++;
            if (o_mem_we) mem[o_mem_addr[AW-1:2]] <= o_mem_wd;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Reference model: byte-addressed semantics computed on whole words.
    task automatic model(input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, output exp_t e, output bit wr, output wr_t w);
        int          nb;
        int          sh;
        bit          legal;
        logic [31:0] word;
        logic [31:0] v;
        logic [31:0] mask;
        nb    = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
        legal = we ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        e.err = !legal || ((a % nb) != 0) || (a >= 32'(MEM_BYTES));
        e.rd  = 32'h0;
        e.acc = 0;
        wr    = 1'b0;
        w.addr = 32'h0;
        w.wd   = 32'h0;
        if (e.err) begin
            e.lat = 1;
            return;
        end
        word = ref_mem[a / 4];
        sh   = int'(a % 4) * 8;
        if (!we) begin
            v = word >> sh;
            if (nb == 1) begin
                v = v & 32'hFF;
                if (!f3[2] && v[7]) v = v | 32'hFFFFFF00;
            end else if (nb == 2) begin
                v = v & 32'hFFFF;
                if (!f3[2] && v[15]) v = v | 32'hFFFF0000;
            end
            e.rd  = v;
            e.lat = 2;
        end else begin
            mask = (nb == 4) ? 32'hFFFFFFFF : (((32'd1 << (8 * nb)) - 32'd1) << sh);
            word = (word & ~mask) | ((wd << sh) & mask);
            ref_mem[a / 4] = word;
            wr     = 1'b1;
            w.addr = a & ~32'd3;
            w.wd   = word;
            e.lat  = (nb == 4) ? 2 : 3;
        end
    endtask

    // Offers a request until accepted; expectations are queued at the negedge before the accept.
    task automatic issue(input bit we, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input bit track);
        int   guard;
        exp_t e;
        bit   wr;
        wr_t  w;
        guard = 0;
        @(negedge i_clk);
        i_req_valid  = 1'b1;
        i_req_we     = we;
        i_req_funct3 = f3;
        i_req_addr   = a;
        i_req_wdata  = wd;
        while (!o_req_ready) begin
            @(negedge i_clk);
            guard++;
            if (guard > 200) begin
                fail("req_accept_timeout");
                i_req_valid = 1'b0;
                return;
            end
        end
        if (track) begin
            model(we, f3, a, wd, e, wr, w);
            e.acc = cyc;
            rq.push_back(e);
            if (wr) wq.push_back(w);
        end
        @(posedge i_clk);
        #1;
        i_req_valid  = 1'b0;
        i_req_we     = 1'($urandom);
        i_req_funct3 = 3'($urandom);
        i_req_addr   = $urandom;
        i_req_wdata  = $urandom;
    endtask

    task automatic wait_idle(input string name);
        int guard;
        guard = 0;
        while ((rq.size() != 0 || wq.size() != 0 || o_rsp_valid) && guard < 300) begin
            @(negedge i_clk);
            guard++;
        end
        if (guard >= 300) fail(name);
    endtask

    // Monitor: compares responses and memory writes, and drives rsp_ready backpressure.
    initial begin
        bit          seen;
        bit          hs;
        int          bp_cnt;
        logic [31:0] held_rd;
        logic        held_err;
        exp_t        e;
        wr_t         w;
        seen = 0;
        hs = 0;
        bp_cnt = 0;
        held_rd = '0;
        held_err = 1'b0;
        i_rsp_ready = 1'b0;
        forever begin
            @(negedge i_clk);
            if (!i_reset) begin
                seen = 0;
                hs = 0;
                bp_cnt = 0;
                i_rsp_ready = 1'b0;
            end else begin
                if (hs) begin
                    check("idle_after_rsp_ready", {31'h0, o_req_ready}, 32'h1);
                    check("rsp_valid_dropped", {31'h0, o_rsp_valid}, 32'h0);
                    seen = 0;
                end
                if (o_mem_we) begin
                    if (wq.size() == 0) begin
                        fail("unexpected_mem_we");
                    end else begin
                        w = wq.pop_front();
                        check("mem_addr", o_mem_addr, w.addr);
                        check("mem_wd", o_mem_wd, w.wd);
                    end
                end
                if (o_rsp_valid) begin
                    check("req_ready_in_resp", {31'h0, o_req_ready}, 32'h0);
                    if (!seen) begin
                        if (rq.size() == 0) begin
                            fail("unexpected_rsp");
                        end else begin
                            e = rq.pop_front();
                            check("rsp_rdata", o_rsp_rdata, e.rd);
                            check("rsp_err", {31'h0, o_rsp_err}, {31'h0, e.err});
                            check("rsp_latency", 32'(cyc - e.acc), 32'(e.lat));
                        end
                        seen = 1;
                        held_rd = o_rsp_rdata;
                        held_err = o_rsp_err;
                    end else begin
                        check("rsp_rdata_stable", o_rsp_rdata, held_rd);
                        check("rsp_err_stable", {31'h0, o_rsp_err}, {31'h0, held_err});
                    end
                end
                if (!bp_on) bp_cnt = 0;
                if (bp_on && o_rsp_valid && bp_cnt < 5) begin
                    i_rsp_ready = 1'b0;
                    bp_cnt++;
                end else begin
                    i_rsp_ready = ($urandom_range(0, 3) != 0);
                end
                hs = o_rsp_valid && i_rsp_ready;
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  f3;
        n_cmp = 0;
        n_bad = 0;
        bp_on = 0;
        i_reset = 1'b0;
        i_req_valid = 1'b0;
        i_req_we = 1'b0;
        i_req_funct3 = 3'b000;
        i_req_addr = 32'h0;
        i_req_wdata = 32'h0;
        for (int i = 0; i < NWORDS; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[4] = 32'h8899AABB;
        ref_mem[4] = 32'h8899AABB;
        mem[8] = 32'h11223344;
        ref_mem[8] = 32'h11223344;

        repeat (3) @(negedge i_clk);
        check("rst_req_ready", {31'h0, o_req_ready}, 32'h1);
        check("rst_rsp_valid", {31'h0, o_rsp_valid}, 32'h0);
        check("rst_rsp_rdata", o_rsp_rdata, 32'h0);
        check("rst_rsp_err", {31'h0, o_rsp_err}, 32'h0);
        check("rst_mem_we", {31'h0, o_mem_we}, 32'h0);
        check("rst_mem_addr", o_mem_addr, 32'h0);
        check("rst_mem_wd", o_mem_wd, 32'h0);
        i_reset = 1'b1;
        #1;
        check("req_ready_after_release", {31'h0, o_req_ready}, 32'h1);

        issue(1'b0, 3'b000, 32'h12, 32'h0, 1'b1);
        issue(1'b0, 3'b100, 32'h12, 32'h0, 1'b1);
        issue(1'b1, 3'b000, 32'h21, 32'hA5, 1'b1);
        issue(1'b1, 3'b010, 32'h20, 32'h11223344, 1'b1);
        issue(1'b1, 3'b001, 32'h22, 32'hBEEF, 1'b1);
        issue(1'b1, 3'b010, 32'h7C, 32'hDEADBEEF, 1'b1);
        issue(1'b0, 3'b010, 32'h7C, 32'h0, 1'b1);
        issue(1'b0, 3'b010, 32'h06, 32'h0, 1'b1);
        issue(1'b1, 3'b001, 32'h03, 32'h1234, 1'b1);
        issue(1'b1, 3'b010, 32'h80, 32'h55AA55AA, 1'b1);
        issue(1'b1, 3'b100, 32'h10, 32'h77, 1'b1);
        wait_idle("drain_directed_timeout");

        bp_on = 1;
        issue(1'b0, 3'b001, 32'h10, 32'h0, 1'b1);
        wait_idle("drain_backpressure_timeout");
        bp_on = 0;

        // Abort an SB in MERGE: nothing may be written, before or after release.
        issue(1'b1, 3'b000, 32'h41, 32'h5A, 1'b0);
        @(posedge i_clk);
        #2;
        i_reset = 1'b0;
        #1;
        check("abort_mem_we", {31'h0, o_mem_we}, 32'h0);
        check("abort_mem_addr", o_mem_addr, 32'h0);
        check("abort_mem_wd", o_mem_wd, 32'h0);
        check("abort_rsp_valid", {31'h0, o_rsp_valid}, 32'h0);
        rq.delete();
        wq.delete();
        @(negedge i_clk);
        i_reset = 1'b1;
        #1;
        check("abort_req_ready", {31'h0, o_req_ready}, 32'h1);
        repeat (4) @(negedge i_clk);
        check("abort_mem_unchanged", mem[16], ref_mem[16]);
        check("abort_no_rsp", {31'h0, o_rsp_valid}, 32'h0);

        for (int n = 0; n < 300; n++) begin
            a = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, MEM_BYTES - 1));
            f3 = 3'($urandom_range(0, 7));
            issue(1'($urandom), f3, a, $urandom, 1'b1);
            repeat ($urandom_range(0, 2)) @(negedge i_clk);
        end
        wait_idle("drain_random_timeout");
        check("rsp_queue_empty", 32'(rq.size()), 32'h0);
        check("write_queue_empty", 32'(wq.size()), 32'h0);
        for (int i = 0; i < NWORDS; i++) begin
            check("final_mem_word", mem[i], ref_mem[i]);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter: MEM_BYTES, default 128, size of the data memory window in bytes (multiple of 4).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 req_valid  input  1  request offered.
REQ-005 req_ready  output  1  controller can accept a request.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I width code (000 B, 001 H, 010 W, 100 BU, 101 HU).
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, LSB-aligned.
REQ-010 rsp_valid  output  1  response available.
REQ-011 rsp_ready  input  1  response consumed.
REQ-012 rsp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-013 rsp_err  output  1  request rejected, no memory write performed.
REQ-014 mem_we  output  1  word write enable to the data memory.
REQ-015 mem_addr  output  32  word-aligned byte address to the data memory.
REQ-016 mem_wd  output  32  word write data.
REQ-017 mem_rd  input  32  combinational word read data from the data memory.

Function
REQ-018 The controller SHALL implement the FSM states IDLE, ACCESS, MERGE and RESP.
REQ-019 req_ready SHALL be 1 only in IDLE; a request is accepted on a clock edge where req_valid and req_ready are both 1, and addr, we, funct3 and wdata are captured.
REQ-020 Error on accept SHALL be: store funct3 not in {000, 001, 010}; load funct3 not in {000, 001, 010, 100, 101}; halfword with addr[0]=1; word with addr[1:0]!=0; addr >= MEM_BYTES.
REQ-021 An erroring request SHALL go IDLE->RESP with rsp_err=1 and rsp_rdata=0, and SHALL never drive mem_we=1.
REQ-022 A valid request SHALL go IDLE->ACCESS.
REQ-023 In ACCESS and MERGE, mem_addr SHALL be {addr[31:2],2'b00}.
REQ-024 In IDLE and RESP, mem_addr SHALL be 0, mem_wd SHALL be 0 and mem_we SHALL be 0.
REQ-025 Load in ACCESS: extract the lane from mem_rd (byte lane addr[1:0], half lane addr[1]).
REQ-026 Load extension: sign-extend for 000/001, zero-extend for 100/101, pass the word for 010.
REQ-027 Load in ACCESS: register the extracted value into rsp_rdata, then ACCESS->RESP.
REQ-028 SW in ACCESS: mem_we=1, mem_wd=wdata, then ACCESS->RESP.
REQ-029 SB/SH in ACCESS: mem_we=0 and the mem_rd word SHALL be registered, then ACCESS->MERGE.
REQ-030 SB/SH in MERGE: mem_we=1 and mem_wd = read word with only the target byte/half lane replaced by wdata[7:0]/wdata[15:0], then MERGE->RESP.
REQ-031 In RESP, rsp_valid SHALL be 1 and rsp_rdata/rsp_err SHALL stay stable until rsp_ready=1.
REQ-032 RESP SHALL go to IDLE on the edge where rsp_ready=1; a new request is accepted no earlier than the following cycle.
REQ-033 Latency from the accept edge to rsp_valid SHALL be: error 1 cycle; load/SW 2 cycles; SB/SH 3 cycles.
REQ-034 mem_we SHALL be asserted for exactly one cycle per valid store and never for a load.
REQ-035 req_valid, req_* and rsp_ready changes outside the accept/RESP conditions SHALL have no effect; there is at most one request in flight.

Reset
REQ-036 reset=0 SHALL asynchronously force IDLE, rsp_valid=0, rsp_err=0, rsp_rdata=0, all captured registers to 0, and mem_we=0, mem_addr=0, mem_wd=0.
REQ-037 Reset asserted during ACCESS or MERGE SHALL abort the operation: no write occurs after reset assertion, and a partial SB/SH merge SHALL not be completed after release.
REQ-038 After reset release, req_ready SHALL be 1 on the first cycle.

Verification
REQ-039 Memory word 0x10 = 0x8899AABB; LB addr 0x12 -> rsp_rdata=0xFFFFFF99, err=0, rsp_valid 2 cycles after accept; LBU addr 0x12 -> 0x00000099.
REQ-040 Word 0x20 = 0x11223344; SB addr 0x21, wdata=0xA5 -> one read cycle, then one mem_we pulse with mem_wd=0x1122A544, rsp 3 cycles after accept; SH addr 0x22, wdata=0xBEEF -> mem_wd=0xBEEF3344.
REQ-041 SW addr 0x7C, wdata=0xDEADBEEF -> a single mem_we pulse with mem_addr=0x7C; a following LW 0x7C -> 0xDEADBEEF.
REQ-042 Errors: LW addr 0x06, SH addr 0x03, SW addr 0x80 and store funct3=100 -> each gives rsp_err=1, rsp_rdata=0, mem_we never 1, rsp 1 cycle after accept.
REQ-043 Backpressure: hold rsp_ready=0 for 5 cycles in RESP -> rsp_valid and data stable, req_ready=0; raise rsp_ready -> IDLE on the next cycle.
REQ-044 Assert reset=0 mid-cycle in MERGE of an SB -> mem_we drops immediately, memory is unchanged, and req_ready=1 after release.
